pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_redirect_buf.sv | 40 ++++
 rtl/pc_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: sequencer states, trap cause
// codes and default boot/trap vectors.
package pc_seq_pkg;

  // Sequencer states; encodings are visible on the seqState debug port
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_TRAP = 2'd3
  } seq_state_t;

  // Cause code reported for an internally raised misaligned-target trap
  localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'h0;

  // Default vectors and boot hold length
  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'hBFC0_0380;
  localparam int unsigned DEF_BOOT_CYCLES  = 2;

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-redirect slot used while a fetch is outstanding.
// A trap capture always overwrites the slot; a plain redirect only fills an
// empty slot. Clearing releases the slot once the fetch completes.
module pc_redirect_buf #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture,
  input  logic                  capture_trap,
  input  logic [ADDR_WIDTH-1:0] capture_target,
  input  logic                  clear,
  output logic                  accept,
  output logic                  pend_valid,
  output logic                  pend_trap,
  output logic [ADDR_WIDTH-1:0] pend_target
);

  // A capture is taken if it is a trap or the slot is currently empty
  always_comb begin
    accept = capture & (capture_trap | ~pend_valid);
  end

  // Slot storage: accepted capture wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid  <= 1'b0;
      pend_trap   <= 1'b0;
      pend_target <= '0;
    end else if (accept) begin
      pend_valid  <= 1'b1;
      pend_trap   <= capture_trap;
      pend_target <= capture_target;
    end else if (clear) begin
      pend_valid  <= 1'b0;
      pend_trap   <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: boot hold, trap/mret/jump/branch/stall selection and
// redirect buffering while an instruction fetch is outstanding.
// Optional feature: define PCSEQ_MISALIGN_TRAP_EN to trap on misaligned
// redirect targets; otherwise target bits [1:0] are forced to zero.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEF_RESET_VECTOR),
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR  = ADDR_WIDTH'(DEF_TRAP_VECTOR),
  parameter int unsigned           BOOT_CYCLES  = DEF_BOOT_CYCLES
) (
  input  logic                  clk,
  input  logic                  triggerRstN,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] incPC,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  jumpValid,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  input  logic                  trapReq,
  input  logic [3:0]            trapCause,
  input  logic                  mretReq,
  input  logic                  stall,
  input  logic                  imemReady,
  output logic [ADDR_WIDTH-1:0] nextPC,
  output logic                  pcRst,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] mepc,
  output logic [3:0]            mcause,
  output logic [1:0]            seqState
);

  localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (BOOT_CYCLES > 1) ? CNT_W'(BOOT_CYCLES - 1) : '0;

  seq_state_t state, next_state;
  logic [CNT_W-1:0] boot_cnt;

  logic [ADDR_WIDTH-1:0] raw_target, redir_target;
  logic                  redir_req, misalign_trap;
  logic                  eff_trap, eff_redir;
  logic [3:0]            eff_cause;

  logic                  flush_fsm, mepc_we;
  logic                  buf_capture, buf_clear, buf_accept;
  logic                  buf_trap;
  logic [ADDR_WIDTH-1:0] buf_target;
  logic                  pend_valid, pend_trap;
  logic [ADDR_WIDTH-1:0] pend_target;

  // Pick the highest-priority non-trap redirect source
  always_comb begin
    raw_target = branchTarget;
    redir_req  = 1'b0;
    if (mretReq) begin
      raw_target = mepc;
      redir_req  = 1'b1;
    end else if (jumpValid) begin
      raw_target = jumpTarget;
      redir_req  = 1'b1;
    end else if (branchTaken) begin
      raw_target = branchTarget;
      redir_req  = 1'b1;
    end
  end

  // Alignment handling of the selected redirect, then final trap/redirect decision
  always_comb begin
`ifdef PCSEQ_MISALIGN_TRAP_EN
    misalign_trap = ~trapReq & redir_req & (|raw_target[1:0]);
    redir_target  = raw_target;
`else
    misalign_trap = 1'b0;
    redir_target  = raw_target & ~ADDR_WIDTH'(3);
`endif
    eff_trap  = trapReq | misalign_trap;
    eff_cause = trapReq ? trapCause : CAUSE_MISALIGNED_FETCH;
    eff_redir = redir_req & ~eff_trap;
  end

  // State register
  always_ff @(posedge clk or negedge triggerRstN) begin
    if (!triggerRstN) state <= ST_BOOT;
    else              state <= next_state;
  end

  // Boot hold counter, saturates on the last boot cycle
  always_ff @(posedge clk or negedge triggerRstN) begin
    if (!triggerRstN) begin
      boot_cnt <= '0;
    end else if (state == ST_BOOT && boot_cnt != CNT_LAST) begin
      boot_cnt <= boot_cnt + 1'b1;
    end
  end

  // Trap context registers
  always_ff @(posedge clk or negedge triggerRstN) begin
    if (!triggerRstN) begin
      mepc   <= '0;
      mcause <= '0;
    end else if (mepc_we) begin
      mepc   <= pc;
      mcause <= eff_cause;
    end
  end

  // Next-state, next-PC and redirect capture control
  always_comb begin
    next_state  = state;
    nextPC      = pc;
    pcRst       = 1'b0;
    flush_fsm   = 1'b0;
    mepc_we     = 1'b0;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    buf_trap    = eff_trap;
    buf_target  = eff_trap ? TRAP_VECTOR : redir_target;

    unique case (state)
      ST_BOOT: begin
        pcRst     = 1'b1;
        nextPC    = RESET_VECTOR;
        flush_fsm = 1'b1;
        if (boot_cnt == CNT_LAST) next_state = ST_RUN;
      end

      ST_RUN: begin
        if (imemReady) begin
          if (eff_trap) begin
            nextPC     = TRAP_VECTOR;
            flush_fsm  = 1'b1;
            mepc_we    = 1'b1;
            next_state = ST_TRAP;
          end else if (eff_redir) begin
            nextPC    = redir_target;
            flush_fsm = 1'b1;
          end else if (stall) begin
            nextPC = pc;
          end else begin
            nextPC = incPC;
          end
        end else begin
          // Fetch outstanding: hold PC, park any redirect until it completes
          next_state  = ST_WAIT;
          buf_capture = eff_trap | eff_redir;
          mepc_we     = eff_trap;
        end
      end

      ST_WAIT: begin
        if (imemReady) begin
          nextPC     = pend_valid ? pend_target : incPC;
          buf_clear  = 1'b1;
          next_state = (pend_valid && pend_trap) ? ST_TRAP : ST_RUN;
        end else begin
          buf_capture = eff_trap | eff_redir;
          mepc_we     = eff_trap;
        end
      end

      ST_TRAP: begin
        nextPC     = pc;
        next_state = ST_RUN;
      end

      default: next_state = ST_BOOT;
    endcase
  end

  // Flush covers immediate redirects and every accepted capture; kept apart
  // from the FSM block so the buffer's accept path does not loop back into it
  always_comb begin
    flush = flush_fsm | buf_accept;
  end

  // Debug view of the sequencer state
  always_comb begin
    seqState = state;
  end

  pc_redirect_buf #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_redirect_buf (
    .clk            (clk),
    .rst_n          (triggerRstN),
    .capture        (buf_capture),
    .capture_trap   (buf_trap),
    .capture_target (buf_target),
    .clear          (buf_clear),
    .accept         (buf_accept),
    .pend_valid     (pend_valid),
    .pend_trap      (pend_trap),
    .pend_target    (pend_target)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with a behavioural reference model.
// Honours PCSEQ_MISALIGN_TRAP_EN the same way as the design build.
module tb_pc_sequencer;

  localparam logic [31:0] RV   = 32'hBFC0_0000;
  localparam logic [31:0] TV   = 32'hBFC0_0380;
  localparam int          BOOT = 2;

  logic        clk = 1'b0;
  logic        triggerRstN = 1'b1;
  logic [31:0] pc, incPC, branchTarget, jumpTarget;
  logic        branchTaken, jumpValid, trapReq, mretReq, stall, imemReady;
  logic [3:0]  trapCause;
  logic [31:0] nextPC, mepc;
  logic        pcRst, flush;
  logic [3:0]  mcause;
  logic [1:0]  seqState;

  pc_sequencer #(
    .ADDR_WIDTH   (32),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .BOOT_CYCLES  (BOOT)
  ) dut (
    .clk          (clk),
    .triggerRstN  (triggerRstN),
    .pc           (pc),
    .incPC        (incPC),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .jumpValid    (jumpValid),
    .jumpTarget   (jumpTarget),
    .trapReq      (trapReq),
    .trapCause    (trapCause),
    .mretReq      (mretReq),
    .stall        (stall),
    .imemReady    (imemReady),
    .nextPC       (nextPC),
    .pcRst        (pcRst),
    .flush        (flush),
    .mepc         (mepc),
    .mcause       (mcause),
    .seqState     (seqState)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // {nextPC, pcRst, flush, mepc, mcause, seqState}
  typedef logic [71:0] vec_t;

  // Reference model: boot cycles left, outstanding-fetch flag, post-trap hold,
  // one pending redirect (queue of at most one), trap context.
  int          m_boot;
  bit          m_fetch_out, m_hold;
  logic [32:0] m_pend[$];          // {is_trap, target}
  logic [31:0] m_mepc;
  logic [3:0]  m_mcause;
  int          n_boot;
  bit          n_fetch_out, n_hold;
  logic [32:0] n_pend[$];
  logic [31:0] n_mepc;
  logic [3:0]  n_mcause;

  function automatic vec_t observed();
    return {nextPC, pcRst, flush, mepc, mcause, seqState};
  endfunction

  function automatic string show(vec_t v);
    return $sformatf("npc=%h rst=%b fl=%b mepc=%h mcause=%h st=%0d",
                     v[71:40], v[39], v[38], v[37:6], v[5:2], v[1:0]);
  endfunction

  task automatic model_reset();
    m_boot = BOOT; m_fetch_out = 0; m_hold = 0;
    m_pend.delete(); m_mepc = '0; m_mcause = '0;
  endtask

  // Which request wins this cycle, after alignment treatment
  task automatic decode(output bit t, output logic [3:0] c, output bit r, output logic [31:0] a);
    logic [31:0] raw;
    t = trapReq; c = trapCause; r = 1'b1; raw = 32'h0;
    if (mretReq)          raw = m_mepc;
    else if (jumpValid)   raw = jumpTarget;
    else if (branchTaken) raw = branchTarget;
    else                  r = 1'b0;
`ifdef PCSEQ_MISALIGN_TRAP_EN
    if (!t && r && raw[1:0] != 2'b00) begin t = 1'b1; c = 4'h0; end
    a = raw;
`else
    a = {raw[31:2], 2'b00};
`endif
    if (t) r = 1'b0;
  endtask

  task automatic predict(output vec_t e);
    logic [31:0] npc, a;
    logic [3:0]  c;
    bit rst, fl, t, r;
    int st;
    n_boot = m_boot; n_fetch_out = m_fetch_out; n_hold = m_hold;
    n_pend = m_pend; n_mepc = m_mepc; n_mcause = m_mcause;
    rst = 0; fl = 0; npc = pc;
    decode(t, c, r, a);
    if (m_boot > 0) begin
      st = 0; npc = RV; rst = 1; fl = 1; n_boot = m_boot - 1;
    end else if (m_hold) begin
      st = 3; n_hold = 0;
    end else begin
      st = m_fetch_out ? 2 : 1;
      if (m_fetch_out && imemReady) begin
        npc = incPC;
        if (m_pend.size() != 0) begin
          npc = m_pend[0][31:0];
          n_hold = m_pend[0][32];
        end
        n_pend.delete(); n_fetch_out = 0;
      end else if (!imemReady) begin
        n_fetch_out = 1;
        if (t) begin
          fl = 1; n_pend.delete(); n_pend.push_back({1'b1, TV});
          n_mepc = pc; n_mcause = c;
        end else if (r && m_pend.size() == 0) begin
          fl = 1; n_pend.push_back({1'b0, a});
        end
      end else if (t) begin
        npc = TV; fl = 1; n_mepc = pc; n_mcause = c; n_hold = 1;
      end else if (r) begin
        npc = a; fl = 1;
      end else if (!stall) begin
        npc = incPC;
      end
    end
    e = {npc, rst, fl, m_mepc, m_mcause, 2'(st)};
  endtask

  task automatic advance();
    @(posedge clk);
    m_boot = n_boot; m_fetch_out = n_fetch_out; m_hold = n_hold;
    m_pend = n_pend; m_mepc = n_mepc; m_mcause = n_mcause;
    #1;
  endtask

  task automatic clear_req();
    branchTaken = 0; jumpValid = 0; trapReq = 0; mretReq = 0; stall = 0;
    trapCause = '0; branchTarget = '0; jumpTarget = '0; imemReady = 1;
  endtask

  task automatic set_pc(input logic [31:0] p);
    pc = p; incPC = p + 32'd4;
  endtask

  // Plain ready cycles with the PC register following nextPC
  task automatic test_quiet(input int n);
    vec_t e;
    clear_req();
    for (int i = 0; i < n; i++) begin
      predict(e); @(negedge clk); vectors++;
      if (observed() !== e) begin
        miscompares++; $display("FAIL quiet[%0d]: got %s want %s", i, show(observed()), show(e));
      end
      advance(); set_pc(e[71:40]);
    end
  endtask

  task automatic test_reset();
    vec_t e;
    clear_req(); set_pc(32'h0);
    triggerRstN = 0; #2;
    model_reset(); predict(e); vectors++;
    if (observed() !== e) begin
      miscompares++; $display("FAIL reset: got %s want %s", show(observed()), show(e));
    end
    @(posedge clk); #1;
    triggerRstN = 1;
  endtask

  task automatic test_boot();
    vec_t e;
    clear_req(); set_pc(RV);
    for (int i = 0; i < BOOT + 1; i++) begin
      predict(e); @(negedge clk); vectors++;
      if (observed() !== e) begin
        miscompares++; $display("FAIL boot[%0d]: got %s want %s", i, show(observed()), show(e));
      end
      vectors++;
      if (i < BOOT && (pcRst !== 1'b1 || nextPC !== RV)) begin
        miscompares++; $display("FAIL boot_hold[%0d]: got rst=%b npc=%h want rst=1 npc=%h", i, pcRst, nextPC, RV);
      end else if (i == BOOT && (pcRst !== 1'b0 || nextPC !== RV + 32'd4)) begin
        miscompares++; $display("FAIL boot_exit: got rst=%b npc=%h want rst=0 npc=%h", pcRst, nextPC, RV + 32'd4);
      end
      advance();
    end
  endtask

  task automatic test_branch_stall();
    vec_t e;
    test_quiet(2);
    set_pc(32'h100); branchTaken = 1; branchTarget = 32'h200; stall = 1;
    predict(e); @(negedge clk); vectors++;
    if (observed() !== e || nextPC !== 32'h200 || flush !== 1'b1) begin
      miscompares++; $display("FAIL branch_stall: got %s want %s", show(observed()), show(e));
    end
    advance(); clear_req(); set_pc(32'h200); stall = 1;
    predict(e); @(negedge clk); vectors++;
    if (observed() !== e || nextPC !== 32'h200 || flush !== 1'b0) begin
      miscompares++; $display("FAIL stall_only: got %s want %s", show(observed()), show(e));
    end
    advance();
  endtask

  task automatic test_trap_mret();
    vec_t e;
    test_quiet(2);
    set_pc(32'h40); trapReq = 1; trapCause = 4'h2; jumpValid = 1; jumpTarget = 32'h80;
    predict(e); @(negedge clk); vectors++;
    if (observed() !== e || nextPC !== TV || flush !== 1'b1) begin
      miscompares++; $display("FAIL trap_take: got %s want %s", show(observed()), show(e));
    end
    advance(); clear_req(); set_pc(TV); mretReq = 1; jumpValid = 1; jumpTarget = 32'h84;
    predict(e); @(negedge clk); vectors++;
    if (observed() !== e || seqState !== 2'd3 || nextPC !== TV || mepc !== 32'h40 || mcause !== 4'h2) begin
      miscompares++; $display("FAIL trap_hold: got %s want %s", show(observed()), show(e));
    end
    advance(); clear_req(); set_pc(TV); mretReq = 1;
    predict(e); @(negedge clk); vectors++;
    if (observed() !== e || nextPC !== 32'h40 || flush !== 1'b1) begin
      miscompares++; $display("FAIL mret: got %s want %s", show(observed()), show(e));
    end
    advance();
  endtask

  task automatic test_wait_pending();
    vec_t e;
    int flushes;
    test_quiet(2);
    flushes = 0;
    set_pc(32'h500);
    for (int i = 0; i < 4; i++) begin
      clear_req(); imemReady = (i == 3);
      if (i == 0) begin jumpValid = 1; jumpTarget = 32'h300; end
      if (i == 1) begin branchTaken = 1; branchTarget = 32'h400; end
      predict(e); @(negedge clk); vectors++;
      if (observed() !== e) begin
        miscompares++; $display("FAIL wait[%0d]: got %s want %s", i, show(observed()), show(e));
      end
      if (flush === 1'b1) flushes++;
      if (i == 3) begin
        vectors++;
        if (nextPC !== 32'h300 || flushes != 1) begin
          miscompares++; $display("FAIL wait_release: got npc=%h flushes=%0d want npc=300 flushes=1", nextPC, flushes);
        end
      end
      advance();
    end
  endtask

  task automatic test_misalign();
    vec_t e;
    test_quiet(2);
    set_pc(32'h600); jumpValid = 1; jumpTarget = 32'h302;
    predict(e); @(negedge clk); vectors++;
`ifdef PCSEQ_MISALIGN_TRAP_EN
    if (observed() !== e || nextPC !== TV || flush !== 1'b1) begin
`else
    if (observed() !== e || nextPC !== 32'h300 || flush !== 1'b1) begin
`endif
      miscompares++; $display("FAIL misalign: got %s want %s", show(observed()), show(e));
    end
    advance(); clear_req(); set_pc(e[71:40]);
    predict(e); @(negedge clk); vectors++;
`ifdef PCSEQ_MISALIGN_TRAP_EN
    if (observed() !== e || mcause !== 4'h0 || mepc !== 32'h600 || seqState !== 2'd3) begin
`else
    if (observed() !== e || seqState !== 2'd1) begin
`endif
      miscompares++; $display("FAIL misalign_after: got %s want %s", show(observed()), show(e));
    end
    advance();
  endtask

  task automatic test_wrap();
    vec_t e;
    test_quiet(2);
    set_pc(32'hFFFF_FFFC);
    predict(e); @(negedge clk); vectors++;
    if (observed() !== e || nextPC !== 32'h0) begin
      miscompares++; $display("FAIL wrap: got %s want %s", show(observed()), show(e));
    end
    advance();
  endtask

  task automatic test_back_to_back();
    vec_t e;
    logic [31:0] tgt [4] = '{32'h1000, 32'h2004, 32'h3008, 32'h0};
    test_quiet(2);
    set_pc(32'h800);
    for (int i = 0; i < 4; i++) begin
      clear_req();
      if (i == 0) begin branchTaken = 1; branchTarget = tgt[i]; end
      if (i == 1) begin jumpValid = 1; jumpTarget = tgt[i]; branchTaken = 1; branchTarget = 32'hDEAD_0000; end
      if (i == 2) begin branchTaken = 1; branchTarget = tgt[i]; stall = 1; end
      predict(e); @(negedge clk); vectors++;
      if (observed() !== e) begin
        miscompares++; $display("FAIL b2b[%0d]: got %s want %s", i, show(observed()), show(e));
      end
      advance(); set_pc(e[71:40]);
    end
  endtask

  task automatic test_random(input int n);
    vec_t e;
    set_pc(32'h1000);
    for (int i = 0; i < n; i++) begin
      imemReady    = ($urandom % 4) != 0;
      trapReq      = ($urandom % 16) == 0;
      trapCause    = 4'($urandom);
      mretReq      = ($urandom % 12) == 0;
      jumpValid    = ($urandom % 6) == 0;
      branchTaken  = ($urandom % 5) == 0;
      stall        = ($urandom % 4) == 0;
      jumpTarget   = $urandom & 32'h0000_FFFC;
      branchTarget = $urandom & 32'h0000_FFFC;
      if ($urandom % 8 == 0) jumpTarget[1:0] = 2'($urandom_range(1, 3));
      if ($urandom % 8 == 0) branchTarget[1:0] = 2'($urandom_range(1, 3));
      predict(e); @(negedge clk); vectors++;
      if (observed() !== e) begin
        miscompares++; $display("FAIL random[%0d]: got %s want %s", i, show(observed()), show(e));
      end
      advance(); set_pc(e[71:40]);
    end
  endtask

  task automatic test_reset_in_wait();
    vec_t e;
    test_quiet(3);
    set_pc(32'h900); imemReady = 0; jumpValid = 1; jumpTarget = 32'h700;
    predict(e); @(negedge clk); vectors++;
    if (observed() !== e || flush !== 1'b1) begin
      miscompares++; $display("FAIL rwait_capture: got %s want %s", show(observed()), show(e));
    end
    advance(); clear_req(); imemReady = 0;
    triggerRstN = 0; #2;
    model_reset(); predict(e); vectors++;
    if (observed() !== e || seqState !== 2'd0 || nextPC !== RV) begin
      miscompares++; $display("FAIL rwait_async: got %s want %s", show(observed()), show(e));
    end
    @(posedge clk); #1;
    triggerRstN = 1; imemReady = 1; set_pc(RV);
    for (int i = 0; i < BOOT + 1; i++) begin
      predict(e); @(negedge clk); vectors++;
      if (observed() !== e) begin
        miscompares++; $display("FAIL rwait_boot[%0d]: got %s want %s", i, show(observed()), show(e));
      end
      advance();
    end
    vectors++;
    if (e[71:40] !== RV + 32'd4) begin
      miscompares++; $display("FAIL rwait_first_fetch: got %h want %h", e[71:40], RV + 32'd4);
    end
  endtask

  initial begin
    clear_req(); set_pc(32'h0);
    #1;
    test_reset();
    test_boot();
    test_branch_stall();
    test_trap_mret();
    test_wait_pending();
    test_misalign();
    test_wrap();
    test_back_to_back();
    test_random(1500);
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
